booth_radix4_multiplier: RTL and testbench

Parametrised, sequential radix-4 Booth multiplier with a start/done handshake and a run-time signed/unsigned mode. It processes two multiplier bits per clock, so an 8-bit multiply takes 5 cycles instead of 8. It is a drop-in arithmetic engine for datapath blocks that issue one multiply at a time and poll or wait on done.

---
 rtl/booth_pkg.sv | 37 +++
 rtl/booth_r4_digit_enc.sv | 37 +++
 rtl/booth_radix4_multiplier.sv | 139 +++++++++++++
 tb/tb_booth_radix4_multiplier.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
//   Shared types and helpers for the radix-4 Booth multiplier.
//   - state_e   : controller state encoding (IDLE / CALC / DONE)
//   - digit_t   : recoded Booth digit as {neg, two, zero}
//   - DIG_*     : the five legal digit encodings
//   - steps()   : number of radix-4 steps for a given operand width
// -----------------------------------------------------------------------------
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // One recoded digit. zero overrides the other two fields; two selects
   // 2*mcand instead of mcand; neg subtracts instead of adds.
   typedef struct packed {
      logic neg;
      logic two;
      logic zero;
   } digit_t;

   localparam digit_t DIG_Z  = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
   localparam digit_t DIG_P1 = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
   localparam digit_t DIG_P2 = '{neg: 1'b0, two: 1'b1, zero: 1'b0};
   localparam digit_t DIG_M1 = '{neg: 1'b1, two: 1'b0, zero: 1'b0};
   localparam digit_t DIG_M2 = '{neg: 1'b1, two: 1'b1, zero: 1'b0};

   // Two multiplier bits per step, plus one extra step so the zero
   // extension bits of an unsigned multiplier are also consumed.
   function automatic int steps(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// -----------------------------------------------------------------------------
// booth_r4_digit_enc
//   Combinational radix-4 Booth recoder: maps a 3-bit overlapping window of
//   the multiplier to a digit in {-2,-1,0,+1,+2}.
//   Ports:
//     bits_i  [2:0]  multiplier window {b(2i+1), b(2i), b(2i-1)}
//     neg_o          digit is negative
//     two_o          digit magnitude is 2
//     zero_o         digit is 0
// -----------------------------------------------------------------------------
module booth_r4_digit_enc
   import booth_pkg::*;
(
   input  logic [2:0] bits_i,
   output logic       neg_o,
   output logic       two_o,
   output logic       zero_o
);

   digit_t dig;

   always_comb begin
      dig = DIG_Z;
      case (bits_i)
         3'b001, 3'b010: dig = DIG_P1;
         3'b011:         dig = DIG_P2;
         3'b100:         dig = DIG_M2;
         3'b101, 3'b110: dig = DIG_M1;
         default:        dig = DIG_Z;   // 000 and 111
      endcase
   end

   assign neg_o  = dig.neg;
   assign two_o  = dig.two;
   assign zero_o = dig.zero;

endmodule

// File: rtl/booth_radix4_multiplier.sv
// -----------------------------------------------------------------------------
// booth_radix4_multiplier
//   Sequential radix-4 Booth multiplier, two multiplier bits per clock,
//   run-time signed/unsigned mode, start/done handshake.
//   Parameter:
//     WIDTH        operand width, even and >= 4
//   Ports:
//     clk          clock, rising edge
//     rst          asynchronous active-low reset
//     start        request a multiply (sampled in IDLE and DONE)
//     signed_mode  1 = two's complement operands, 0 = unsigned
//     multi        multiplicand  [WIDTH-1:0]
//     multiplier   multiplier    [WIDTH-1:0]
//     busy         high while in CALC
//     done         one-cycle pulse when product is valid
//     product      result [2*WIDTH-1:0], held until the next completion
//   Build option:
//     BOOTH_EARLY_TERM_EN  finish as soon as every remaining digit is zero.
// -----------------------------------------------------------------------------
module booth_radix4_multiplier
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multi,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW = 2 * WIDTH;
   localparam int MW = WIDTH + 3;
   localparam int N  = steps(WIDTH);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e          state_q,   state_d;
   logic [PW-1:0]   mcand_q,   mcand_d;
   logic [MW-1:0]   mplr_q,    mplr_d;
   logic [PW-1:0]   acc_q,     acc_d;
   logic [CW-1:0]   cnt_q,     cnt_d;
   logic [PW-1:0]   product_q, product_d;

   logic            dig_neg, dig_two, dig_zero;
   logic [PW-1:0]   mag;
   logic [PW-1:0]   acc_step;
   logic [MW-1:0]   mplr_step;
   logic            last_step;
   logic            ext;

   booth_r4_digit_enc u_enc (
      .bits_i (mplr_q[2:0]),
      .neg_o  (dig_neg),
      .two_o  (dig_two),
      .zero_o (dig_zero)
   );

   // Partial product for the current digit; the sum wraps modulo 2^PW,
   // which is exactly what the final product needs.
   always_comb begin
      mag = dig_two ? {mcand_q[PW-2:0], 1'b0} : mcand_q;
      if (dig_zero) mag = '0;
      acc_step  = dig_neg ? (acc_q - mag) : (acc_q + mag);
      mplr_step = {{2{mplr_q[MW-1]}}, mplr_q[MW-1:2]};
   end

`ifdef BOOTH_EARLY_TERM_EN
   // Once the shifted multiplier is all zeros or all ones, every further
   // window recodes to 0, so the accumulator is already final.
   assign last_step = (cnt_q == LAST) || (mplr_step == '0) || (&mplr_step);
`else
   assign last_step = (cnt_q == LAST);
`endif

   assign ext = signed_mode & multiplier[WIDTH-1];

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d = signed_mode ? {{WIDTH{multi[WIDTH-1]}}, multi}
                                     : {{WIDTH{1'b0}}, multi};
               mplr_d  = {ext, ext, multiplier, 1'b0};
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            acc_d   = acc_step;
            mcand_d = {mcand_q[PW-3:0], 2'b00};
            mplr_d  = mplr_step;
            cnt_d   = cnt_q + CW'(1);
            if (last_step) begin
               product_d = acc_step;
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == CALC);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// -----------------------------------------------------------------------------
// tb_booth_radix4_multiplier
//   Self-checking bench: directed cases plus random operands compared against
//   a plain integer-multiply reference, including latency, busy width,
//   handshake corner cases and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_booth_radix4_multiplier;

   localparam int W = 8;
   localparam int N = W / 2 + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           signed_mode = 1'b0;
   logic [W-1:0]   multi = '0;
   logic [W-1:0]   multiplier = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   booth_radix4_multiplier #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_mode (signed_mode),
      .multi       (multi),
      .multiplier  (multiplier),
      .busy        (busy),
      .done        (done),
      .product     (product)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic sm, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      longint ma, mb, p;
      ma = sm ? longint'($signed(a)) : longint'(a);
      mb = sm ? longint'($signed(b)) : longint'(b);
      p  = ma * mb;
      return p[2*W-1:0];
   endfunction

   // Cycles from accept to done: N normally; with early termination, the
   // first step count after which the unconsumed multiplier bits are a pure
   // sign/zero extension.
   function automatic int exp_lat(input logic sm, input logic [W-1:0] b);
`ifdef BOOTH_EARLY_TERM_EN
      longint m;
      m = sm ? longint'($signed(b)) : longint'(b);
      for (int k = 1; k <= N; k++)
         if ((m >>> (2*k-1)) == 0 || (m >>> (2*k-1)) == -1) return k;
      return N;
`else
      return N + 0 * int'(sm) + 0 * int'(b);
`endif
   endfunction

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic start_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
      signed_mode = sm;
      multi       = a;
      multiplier  = b;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts negedges until done (bounded). poke drives a new start and new
   // operands in mid-calculation, which must be ignored.
   task automatic wait_done(output int lat, output int bc, input bit poke);
      lat = 0;
      bc  = 0;
      while (!done && lat < 4*N) begin
         if (busy) bc++;
         if (poke && lat == 1) begin
            start       = 1'b1;
            multi       = ~multi;
            multiplier  = multiplier + 8'h35;
            signed_mode = ~signed_mode;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic run(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                      input string tag, input bit poke);
      logic [2*W-1:0] exp;
      int el, lat, bc;
      exp = ref_mul(sm, a, b);
      el  = exp_lat(sm, b);
      @(negedge clk);
      start_op(sm, a, b);
      wait_done(lat, bc, poke);
      chk({tag, "/lat"},  lat, el);
      chk({tag, "/busy"}, bc, el);
      chk({tag, "/prod"}, product, exp);
      @(negedge clk);
      chk({tag, "/done_fall"}, done, 1'b0);
      chk({tag, "/hold"}, product, exp);
   endtask

   initial begin
      int lat, bc, dcnt;
      logic [W-1:0] a, b;
      logic sm;

      // Reset state
      #2 rst = 1'b0;
      #3;
      chk("rst/busy", busy, 1'b0);
      chk("rst/done", done, 1'b0);
      chk("rst/prod", product, '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Directed cases
      run(1'b1, 8'hCB, 8'h0E, "s_cb_0e", 1'b0);
      run(1'b1, 8'hEC, 8'hCC, "s_ec_cc", 1'b0);
      run(1'b1, 8'h80, 8'h80, "s_80_80", 1'b0);
      run(1'b1, 8'hFF, 8'hFE, "s_ff_fe", 1'b0);
      run(1'b0, 8'hFF, 8'hFE, "u_ff_fe", 1'b0);
      run(1'b0, 8'hFF, 8'hFF, "u_ff_ff", 1'b0);
      run(1'b1, 8'h03, 8'h05, "s_03_05", 1'b0);
      run(1'b1, 8'h5A, 8'h00, "s_mplr0", 1'b0);
      run(1'b1, 8'h07, 8'hFF, "s_07_ff", 1'b0);
      run(1'b0, 8'h80, 8'h80, "u_80_80", 1'b0);

      // start during CALC is ignored
      run(1'b1, 8'hCB, 8'h0E, "poke", 1'b1);

      // Back-to-back: start accepted in the DONE cycle
      @(negedge clk);
      start_op(1'b1, 8'hCB, 8'h0E);
      wait_done(lat, bc, 1'b0);
      chk("b2b1/prod", product, ref_mul(1'b1, 8'hCB, 8'h0E));
      start_op(1'b0, 8'hFF, 8'hFE);
      wait_done(lat, bc, 1'b0);
      chk("b2b2/lat",  lat, exp_lat(1'b0, 8'hFE));
      chk("b2b2/prod", product, ref_mul(1'b0, 8'hFF, 8'hFE));
      @(negedge clk);
      chk("b2b2/done_fall", done, 1'b0);

      // Asynchronous reset in the middle of a calculation
      @(negedge clk);
      start_op(1'b0, 8'hC7, 8'hB3);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst/busy", busy, 1'b0);
      chk("arst/done", done, 1'b0);
      chk("arst/prod", product, '0);
      @(negedge clk);
      rst = 1'b1;
      dcnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      chk("arst/no_stale", dcnt, 0);
      run(1'b1, 8'h9D, 8'h6B, "post_rst", 1'b0);

      // Random operands
      for (int i = 0; i < 40; i++) begin
         a  = W'($urandom);
         b  = W'($urandom);
         sm = 1'($urandom);
         run(sm, a, b, $sformatf("rnd%0d", i), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
